ad3542_spi_tx: RTL

//  Consumer end of the sequencer's data_out/valid_out sample stream. It buffers samples
//  in a small FIFO and serializes each one as a 24-bit SPI write frame to the AD3542 DAC.
//  The sequencer has no backpressure, so overflow is detected and flagged, never stalled.

---
 rtl/ad3542_spi_tx.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/ad3542_spi_tx.sv
`timescale 1ns/1ps
// ad3542_spi_tx
//   Buffers 16-bit samples from the sequencer in a small FIFO and serializes
//   each one as a 24-bit SPI write frame {1'b0, REG_ADDR, data} to an AD3542.
//   The producer cannot be stalled: a sample arriving on a full FIFO is
//   dropped and the sticky overflow flag is raised.
//
// Configuration macro: AD3542_LDAC_PULSE_EN
//   defined   : ldac_n pulses low for LDAC_W cycles starting one cycle after
//               cs_n rises; the inter-frame gap stretches to cover the pulse.
//   undefined : ldac_n held at 1 (DAC auto-update mode).
//
// Ports
//   clk            in   system clock
//   reset          in   asynchronous, active-high reset
//   data_in[15:0]  in   sample
//   valid_in       in   sample strobe, at most one per cycle
//   clear_overflow in   one-cycle pulse, clears overflow (a same-cycle drop wins)
//   busy           out  FIFO non-empty or serializer active
//   overflow       out  sticky sample-dropped flag
//   cs_n           out  SPI chip select, active low
//   sclk           out  SPI clock, mode 0
//   sdo            out  SPI data, MSB first, changes while sclk is low
//   ldac_n         out  DAC load strobe, active low
module ad3542_spi_tx #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned CS_GAP   = 4,
  parameter int unsigned FIFO_AW  = 4,
  parameter logic [6:0]  REG_ADDR = 7'h2C,
  parameter int unsigned LDAC_W   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data_in,
  input  logic        valid_in,
  input  logic        clear_overflow,
  output logic        busy,
  output logic        overflow,
  output logic        cs_n,
  output logic        sclk,
  output logic        sdo,
  output logic        ldac_n
);

`ifdef AD3542_LDAC_PULSE_EN
  localparam logic LDAC_EN = 1'b1;
`else
  localparam logic LDAC_EN = 1'b0;
`endif

  localparam int unsigned DEPTH   = 2 ** FIFO_AW;
  // The gap must outlast the ldac_n pulse so cs_n never falls while it is low.
  localparam int unsigned GAP_LEN = (LDAC_EN && (LDAC_W > CS_GAP)) ? LDAC_W : CS_GAP;
  localparam int unsigned CNT_W   = 16;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_LEN - 1);
  localparam logic [CNT_W-1:0] LDAC_LEN = CNT_W'(LDAC_W);
  localparam logic [4:0]       BIT_LAST = 5'd23;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [4:0]         bit_q, bit_d;
  logic [23:0]        shift_q, shift_d;
  logic               cs_n_q, cs_n_d;
  logic               sclk_q, sclk_d;
  logic               sdo_q, sdo_d;
  logic               ldac_n_q, ldac_n_d;
  logic               busy_q, busy_d;
  logic               overflow_q, overflow_d;

  logic [15:0]        mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;

  logic               fifo_empty_s;
  logic               fifo_full_s;
  logic               pop_s;
  logic               push_s;
  logic               drop_s;
  logic [23:0]        frame_s;

  assign fifo_empty_s = (count_q == '0);
  assign fifo_full_s  = (count_q == (FIFO_AW+1)'(DEPTH));
  assign pop_s        = (state_q == S_IDLE) && !fifo_empty_s;
  // A full FIFO still accepts a sample when the head leaves in the same cycle.
  assign push_s       = valid_in && (!fifo_full_s || pop_s);
  assign drop_s       = valid_in && fifo_full_s && !pop_s;
  assign frame_s      = {1'b0, REG_ADDR, mem_q[rd_ptr_q]};

  // FIFO pointer/occupancy and sticky overflow next-state
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (FIFO_AW+1)'(1);
      2'b01:   count_d = count_q - (FIFO_AW+1)'(1);
      default: count_d = count_q;
    endcase
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Serializer FSM next-state and registered-output values
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    cs_n_d   = cs_n_q;
    sclk_d   = sclk_q;
    sdo_d    = sdo_q;
    ldac_n_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty_s) begin
          shift_d = frame_s;
          sdo_d   = frame_s[23];
          cs_n_d  = 1'b0;
          cnt_d   = '0;
          bit_d   = 5'd0;
          state_d = S_SETUP;
        end else begin
          cs_n_d  = 1'b1;
          sclk_d  = 1'b0;
        end
      end
      S_SETUP: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          sclk_d  = 1'b1;
          state_d = S_SHIFT;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (sclk_q) begin
            // Falling edge: present the next bit for the following rising edge.
            sclk_d  = 1'b0;
            shift_d = {shift_q[22:0], 1'b0};
            sdo_d   = shift_q[22];
          end else if (bit_q == BIT_LAST) begin
            state_d = S_HOLD;
          end else begin
            bit_d   = bit_q + 5'd1;
            sclk_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          cs_n_d  = 1'b1;
          sdo_d   = 1'b0;
          state_d = S_GAP;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        // ldac_n is low on the LDAC_W edges following the cs_n rise.
        if (LDAC_EN && (cnt_q < LDAC_LEN)) begin
          ldac_n_d = 1'b0;
        end else begin
          ldac_n_d = 1'b1;
        end
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        bit_d   = 5'd0;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
        sdo_d   = 1'b0;
      end
    endcase
    busy_d = (count_d != '0) || (state_d != S_IDLE);
  end

  // Control and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= 5'd0;
      shift_q    <= 24'd0;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b0;
      sdo_q      <= 1'b0;
      ldac_n_q   <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      cs_n_q     <= cs_n_d;
      sclk_q     <= sclk_d;
      sdo_q      <= sdo_d;
      ldac_n_q   <= ldac_n_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage; contents need no reset since occupancy is tracked separately
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign busy     = busy_q;
  assign overflow = overflow_q;
  assign cs_n     = cs_n_q;
  assign sclk     = sclk_q;
  assign sdo      = sdo_q;
  assign ldac_n   = ldac_n_q;

endmodule
